// File: rtl/sprite_update_queue.sv
// Sprite register-write queue: host writes are buffered in a FIFO, grouped by a
// commit pulse, and replayed back-to-back to the sprite engine on the next vsync rise.
module sprite_update_queue #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [5:0]    push_addr,
   input  logic [15:0]   push_data,
   input  logic          commit,
   input  logic          vsync,
   output logic [1:0]    wr_n,
   output logic [5:0]    wr_addr,
   output logic [31:0]   wr_data,
   output logic          busy,
   output logic [CW-1:0] level,
   output logic          batch_done,
   output logic          overflow,
   input  logic          clear_overflow
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t        state;
   logic [21:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] committed_cnt;
   logic [CW-1:0] drain_cnt;
   logic          vsync_q;
   logic          push_ok;
   logic          pop;
   logic          rise;
   logic [21:0]   head;

   assign push_ready = (count != CW'(DEPTH));
   assign level      = count;
   assign head       = mem[rd_ptr];

   always_comb begin
      push_ok = push_valid && push_ready;
      pop     = (state == DRAIN) && (count != {CW{1'b0}});
      rise    = vsync && !vsync_q;
   end

   // Entry storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {push_addr, push_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {PW{1'b0}};
         rd_ptr <= {PW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A commit snapshots what remains after this cycle's pop; a same-cycle push is excluded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         committed_cnt <= {CW{1'b0}};
      end else if (commit) begin
         committed_cnt <= count - CW'(pop);
      end else if (pop && (committed_cnt != {CW{1'b0}})) begin
         committed_cnt <= committed_cnt - 1'b1;
      end else begin
         committed_cnt <= committed_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         vsync_q  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         if (push_valid && !push_ready) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end else begin
            overflow <= overflow;
         end
      end
   end

   // drain_cnt is latched once per frame, so a commit mid-drain only affects the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         drain_cnt  <= {CW{1'b0}};
         wr_n       <= 2'b11;
         wr_addr    <= 6'h00;
         wr_data    <= 32'h0000_0000;
         busy       <= 1'b0;
         batch_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wr_n       <= 2'b11;
               batch_done <= 1'b0;
               if (rise && (committed_cnt != {CW{1'b0}})) begin
                  drain_cnt <= committed_cnt;
                  state     <= DRAIN;
                  busy      <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            DRAIN: begin
               wr_n      <= 2'b01;
               wr_addr   <= head[21:16];
               wr_data   <= {16'h0000, head[15:0]};
               drain_cnt <= drain_cnt - 1'b1;
               if (drain_cnt == CW'(1)) begin
                  batch_done <= 1'b1;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end else begin
                  batch_done <= 1'b0;
                  state      <= DRAIN;
                  busy       <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               wr_n       <= 2'b11;
               busy       <= 1'b0;
               batch_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_update_queue.sv
// Self-checking bench for sprite_update_queue: directed scenarios plus random
// traffic, each cycle compared against a queue-based behavioural model.
module tb_sprite_update_queue;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int VW    = 44 + CW;

   logic          clk = 1'b0;
   logic          rst;
   logic          push_valid;
   logic [5:0]    push_addr;
   logic [15:0]   push_data;
   logic          commit;
   logic          vsync;
   logic          clear_overflow;
   wire           push_ready;
   wire  [1:0]    wr_n;
   wire  [5:0]    wr_addr;
   wire  [31:0]   wr_data;
   wire           busy;
   wire  [CW-1:0] level;
   wire           batch_done;
   wire           overflow;

   sprite_update_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
      .push_addr(push_addr), .push_data(push_data), .commit(commit), .vsync(vsync),
      .wr_n(wr_n), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .level(level),
      .batch_done(batch_done), .overflow(overflow), .clear_overflow(clear_overflow)
   );

   always #5 clk = ~clk;

   wire [VW-1:0] dut_vec = {wr_n, wr_addr, wr_data, busy, batch_done, level, overflow, push_ready};

   int vectors = 0;
   int miscompares = 0;
   int writes = 0;

   // Behavioural model: FIFO contents as queues, batch bookkeeping as plain integers.
   logic [5:0]  mq_addr [$];
   logic [15:0] mq_data [$];
   int          m_comm;
   int          m_drain;
   bit          m_busy, m_done, m_ovf, m_vq;
   logic [1:0]  m_wr_n;
   logic [5:0]  m_wr_addr;
   logic [31:0] m_wr_data;

   function automatic logic [VW-1:0] model_vec();
      int sz = mq_addr.size();
      return {m_wr_n, m_wr_addr, m_wr_data, m_busy, m_done, CW'(sz), m_ovf, (sz != DEPTH)};
   endfunction

   task automatic model_reset();
      mq_addr.delete();
      mq_data.delete();
      m_comm = 0; m_drain = 0;
      m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_vq = 1'b0;
      m_wr_n = 2'b11; m_wr_addr = 6'h00; m_wr_data = 32'h0;
   endtask

   // Advance the model on the current inputs, then let the DUT take the same edge.
   task automatic tick();
      int sz;
      bit pop, push_ok, rise;
      sz = mq_addr.size();
      if (rst) begin
         model_reset();
      end else begin
         pop     = m_busy;
         push_ok = push_valid && (sz < DEPTH);
         rise    = vsync && !m_vq;
         if (m_busy) begin
            m_wr_n    = 2'b01;
            m_wr_addr = mq_addr[0];
            m_wr_data = {16'h0000, mq_data[0]};
            m_done    = (m_drain == 1);
            m_drain   = m_drain - 1;
            if (m_done) m_busy = 1'b0;
         end else begin
            m_wr_n = 2'b11;
            m_done = 1'b0;
            if (rise && m_comm > 0) begin
               m_drain = m_comm;
               m_busy  = 1'b1;
            end
         end
         if (commit) m_comm = sz - int'(pop);
         else if (pop && m_comm > 0) m_comm = m_comm - 1;
         if (push_valid && sz == DEPTH) m_ovf = 1'b1;
         else if (clear_overflow) m_ovf = 1'b0;
         if (pop) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
         end
         if (push_ok) begin
            mq_addr.push_back(push_addr);
            mq_data.push_back(push_data);
         end
         m_vq = vsync;
      end
      @(posedge clk);
      #1;
      if (wr_n === 2'b01) writes++;
   endtask

   task automatic idle_inputs();
      push_valid = 1'b0; commit = 1'b0; clear_overflow = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; vsync = 1'b0; push_addr = 6'h00; push_data = 16'h0000;
      idle_inputs();
      tick(); tick();
      vectors++;
      if (dut_vec !== {2'b11, 6'h00, 32'h0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0, 1'b1}) begin
         miscompares++; $display("FAIL reset_values: dut=%h required=%h", dut_vec,
            {2'b11, 6'h00, 32'h0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0, 1'b1});
      end
      rst = 1'b0;
   endtask

   task automatic test_no_commit();
      logic [5:0]  a [3];
      logic [15:0] d [3];
      a = '{6'h04, 6'h06, 6'h08};
      d = '{16'h1020, 16'hAAAA, 16'h5555};
      writes = 0;
      for (int i = 0; i < 9; i++) begin
         idle_inputs();
         if (i < 3) begin push_valid = 1'b1; push_addr = a[i]; push_data = d[i]; end
         vsync = (i >= 4 && i <= 6);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL no_commit cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      vectors++;
      if (writes !== 0 || level !== CW'(3)) begin
         miscompares++; $display("FAIL no_commit_writes: writes=%0d level=%0d required 0/3", writes, level);
      end
   endtask

   task automatic test_drain();
      logic [5:0] got [$];
      writes = 0;
      for (int i = 0; i < 8; i++) begin
         idle_inputs();
         commit = (i == 0);
         vsync  = (i >= 1);
         tick();
         if (wr_n === 2'b01) got.push_back(wr_addr);
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL drain cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
         if (i == 4) begin
            vectors++;
            if (batch_done !== 1'b1 || wr_data !== 32'h0000_5555 || wr_n !== 2'b01) begin
               miscompares++; $display("FAIL drain_last: done=%b data=%h wr_n=%b required 1/00005555/01",
                  batch_done, wr_data, wr_n);
            end
         end
      end
      vectors++;
      if (writes !== 3 || got.size() != 3 || level !== {CW{1'b0}} || busy !== 1'b0) begin
         miscompares++; $display("FAIL drain_count: writes=%0d level=%0d busy=%b required 3/0/0", writes, level, busy);
      end else begin
         vectors++;
         if (got[0] !== 6'h04 || got[1] !== 6'h06 || got[2] !== 6'h08) begin
            miscompares++; $display("FAIL drain_order: got %h %h %h required 04 06 08", got[0], got[1], got[2]);
         end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH + 3; i++) begin
         idle_inputs();
         vsync = 1'b0;
         push_valid = (i <= DEPTH + 1);
         clear_overflow = (i >= DEPTH + 1);
         push_addr = 6'($urandom); push_data = 16'($urandom);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL overflow cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
         vectors++;
         if (i == DEPTH && (push_ready !== 1'b0 || overflow !== 1'b1)) begin
            miscompares++; $display("FAIL overflow_set: ready=%b ovf=%b required 0/1", push_ready, overflow);
         end else if (i == DEPTH + 1 && overflow !== 1'b1) begin
            miscompares++; $display("FAIL overflow_set_wins: ovf=%b required 1", overflow);
         end else if (i == DEPTH + 2 && overflow !== 1'b0) begin
            miscompares++; $display("FAIL overflow_clear: ovf=%b required 0", overflow);
         end
      end
      writes = 0;
      for (int i = 0; i < DEPTH + 4; i++) begin
         idle_inputs();
         commit = (i == 0);
         vsync  = (i >= 1);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL full_drain cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      vectors++;
      if (writes !== DEPTH || level !== {CW{1'b0}}) begin
         miscompares++; $display("FAIL full_drain_count: writes=%0d level=%0d required %0d/0", writes, level, DEPTH);
      end
   endtask

   task automatic test_commit_during_drain();
      writes = 0;
      for (int i = 0; i < 14; i++) begin
         idle_inputs();
         push_valid = (i < 4) || (i == 6) || (i == 7);
         push_addr = 6'(i + 16); push_data = 16'($urandom);
         commit = (i == 4) || (i == 8);
         vsync  = (i >= 5);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL cdd_frame1 cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      vectors++;
      if (writes !== 4) begin
         miscompares++; $display("FAIL cdd_frame1_writes: writes=%0d required 4", writes);
      end
      writes = 0;
      for (int i = 0; i < 8; i++) begin
         idle_inputs();
         vsync = (i >= 2);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL cdd_frame2 cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      vectors++;
      if (writes !== 2 || level !== {CW{1'b0}}) begin
         miscompares++; $display("FAIL cdd_frame2_writes: writes=%0d level=%0d required 2/0", writes, level);
      end
   endtask

   task automatic test_commit_push_same();
      writes = 0;
      for (int i = 0; i < 9; i++) begin
         idle_inputs();
         push_valid = (i <= 2);
         push_addr = 6'(i + 32); push_data = 16'($urandom);
         commit = (i == 2);
         vsync  = (i >= 3);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL cps_frame1 cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      vectors++;
      if (writes !== 2 || level !== CW'(1)) begin
         miscompares++; $display("FAIL cps_frame1_writes: writes=%0d level=%0d required 2/1", writes, level);
      end
      writes = 0;
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         commit = (i == 0);
         vsync  = (i >= 2);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL cps_frame2 cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      vectors++;
      if (writes !== 1 || level !== {CW{1'b0}}) begin
         miscompares++; $display("FAIL cps_frame2_writes: writes=%0d level=%0d required 1/0", writes, level);
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 9; i++) begin
         idle_inputs();
         push_valid = (i < 5);
         push_addr = 6'(i + 48); push_data = 16'($urandom);
         commit = (i == 5);
         vsync  = (i >= 6);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL rmd_setup cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      rst = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (wr_n !== 2'b11 || level !== {CW{1'b0}} || dut_vec !== model_vec()) begin
         miscompares++; $display("FAIL rmd_async: wr_n=%b level=%0d dut=%h required 11/0/%h",
            wr_n, level, dut_vec, model_vec());
      end
      tick();
      rst = 1'b0;
      writes = 0;
      for (int i = 0; i < 12; i++) begin
         idle_inputs();
         vsync = ((i % 4) >= 2);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL rmd_after cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      vectors++;
      if (writes !== 0) begin
         miscompares++; $display("FAIL rmd_no_writes: writes=%0d required 0", writes);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         push_valid     = ($urandom_range(0, 1) == 1);
         push_addr      = 6'($urandom);
         push_data      = 16'($urandom);
         commit         = ($urandom_range(0, 9) == 0);
         clear_overflow = ($urandom_range(0, 19) == 0);
         vsync          = ((i % 37) < 4);
         tick();
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++; $display("FAIL random cyc%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      idle_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_no_commit();
      test_drain();
      test_overflow();
      test_commit_during_drain();
      test_commit_push_same();
      test_reset_mid_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
